preg_free_list: RTL and testbench

- LIFO free-list manager for the physical register pool behind the rename map.
- Grants one physical register per cycle to the rename stage.
- Accepts up to two releases per cycle, from the commit/dealloc path and the writeback path.
- Guards the pool against double-release and release of pr0. Sits beside renaming_map; owns pool occupancy.

---
 rtl/renaming_pkg.sv | 17 +
 rtl/preg_lifo.sv | 66 ++++++
 rtl/preg_free_list.sv | 85 ++++++++
 tb/tb_preg_free_list.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/renaming_pkg.sv
// Shared definitions for the register renaming slice.
//   NR_PHYS_REGS   : size of the physical register pool (pr0 is permanently mapped)
//   PHYS_REG_WIDTH : physical register index width, clog2(NR_PHYS_REGS)
//   preg_t         : physical register index type
//   PREG_ZERO      : index of the hard-mapped register pr0
//   STACK_DEPTH    : number of allocatable registers (pool minus pr0)
package renaming_pkg;

    localparam int NR_PHYS_REGS   = 64;
    localparam int PHYS_REG_WIDTH = 6;
    localparam int STACK_DEPTH    = NR_PHYS_REGS - 1;

    typedef logic [PHYS_REG_WIDTH-1:0] preg_t;

    localparam preg_t PREG_ZERO = '0;

endpackage

// File: rtl/preg_lifo.sv
// Stack of physical register indices with one pop and two ordered pushes per cycle.
// Within one edge the order is: pop, then push0, then push1 (push1 ends on top).
// Reset fills the stack so that the top holds pr1, then pr2, ... down to pr63 at index 0.
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   pop_i             : remove the current top this edge (caller guarantees count_o != 0)
//   push0_i/_data_i   : first push this edge
//   push1_i/_data_i   : second push this edge (lands above push0 when both are set)
//   top_o             : current top of stack, PREG_ZERO when empty
//   count_o           : number of entries held
module preg_lifo
    import renaming_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  pop_i,
    input  logic  push0_i,
    input  preg_t push0_data_i,
    input  logic  push1_i,
    input  preg_t push1_data_i,
    output preg_t top_o,
    output preg_t count_o
);

    preg_t stack_q [STACK_DEPTH];
    preg_t count_q;
    preg_t top_idx;
    preg_t cnt_after_pop;
    preg_t cnt_after_push0;

    // Slot positions follow the pop -> push0 -> push1 order, so each push
    // writes directly above whatever the previous step left on top.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        top_idx         = count_q - preg_t'(1);
        cnt_after_pop   = count_q - preg_t'(pop_i);
        cnt_after_push0 = cnt_after_pop + preg_t'(push0_i);
        top_o           = PREG_ZERO;
        if (count_q != PREG_ZERO) begin
            top_o = stack_q[top_idx];
        end
    end

    // NOTE: the stack is an array of flops with reset because its power-up
    // contents (the initial allocation order) are architecturally visible.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= preg_t'(STACK_DEPTH);
            for (int k = 0; k < STACK_DEPTH; k++) begin
                stack_q[k] <= preg_t'(STACK_DEPTH - k);
            end
        end else begin
            count_q <= cnt_after_push0 + preg_t'(push1_i);
            if (push0_i) begin
                stack_q[cnt_after_pop] <= push0_data_i;
            end
            if (push1_i) begin
                stack_q[cnt_after_push0] <= push1_data_i;
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/preg_free_list.sv
// LIFO free-list manager for the physical register pool behind the rename map.
// Grants one register per cycle (zero latency) and accepts up to two releases
// per cycle; illegal releases (pr0, already-free, duplicate of port 0) are dropped
// and flagged one cycle later on rel_error_o.
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   alloc_req_i             : rename stage wants one register this cycle
//   alloc_gnt_o             : request granted (pool not empty)
//   alloc_preg_o            : register handed out on grant (top of stack, 0 when empty)
//   rel0_valid_i/_preg_i    : release port 0 (commit dealloc)
//   rel1_valid_i/_preg_i    : release port 1 (writeback)
//   free_count_o            : registered number of free registers
//   empty_o                 : no free register available
//   rel_error_o             : an illegal release was dropped in the previous cycle
module preg_free_list
    import renaming_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  alloc_req_i,
    output logic  alloc_gnt_o,
    output preg_t alloc_preg_o,
    input  logic  rel0_valid_i,
    input  preg_t rel0_preg_i,
    input  logic  rel1_valid_i,
    input  preg_t rel1_preg_i,
    output preg_t free_count_o,
    output logic  empty_o,
    output logic  rel_error_o
);

    localparam logic [NR_PHYS_REGS-1:0] FREE_MAP_RESET = {{(NR_PHYS_REGS-1){1'b1}}, 1'b0};

    logic [NR_PHYS_REGS-1:0] free_map_q;
    logic                    rel_error_q;
    logic                    legal0;
    logic                    legal1;
    preg_t                   count;

    preg_lifo u_lifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pop_i        (alloc_gnt_o),
        .push0_i      (legal0),
        .push0_data_i (rel0_preg_i),
        .push1_i      (legal1),
        .push1_data_i (rel1_preg_i),
        .top_o        (alloc_preg_o),
        .count_o      (count)
    );

    // Legality is judged on the pre-edge bitmap: a register granted this very
    // cycle is still marked free, so releasing it is rejected.
    always_comb begin
        empty_o     = (count == PREG_ZERO);
        alloc_gnt_o = alloc_req_i && !empty_o;
        legal0      = rel0_valid_i && (rel0_preg_i != PREG_ZERO) && !free_map_q[rel0_preg_i];
        legal1      = rel1_valid_i && (rel1_preg_i != PREG_ZERO) && !free_map_q[rel1_preg_i]
                      && !(legal0 && (rel1_preg_i == rel0_preg_i));
    end

    // The granted register is free pre-edge and released ones are allocated
    // pre-edge, so the clear and the sets never touch the same bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            free_map_q  <= FREE_MAP_RESET;
            rel_error_q <= 1'b0;
        end else begin
            if (alloc_gnt_o) begin
                free_map_q[alloc_preg_o] <= 1'b0;
            end
            if (legal0) begin
                free_map_q[rel0_preg_i] <= 1'b1;
            end
            if (legal1) begin
                free_map_q[rel1_preg_i] <= 1'b1;
            end
            rel_error_q <= (rel0_valid_i && !legal0) || (rel1_valid_i && !legal1);
        end
    end

    assign free_count_o = count;
    assign rel_error_o  = rel_error_q;

endmodule

// File: tb/tb_preg_free_list.sv
// Scoreboard bench for preg_free_list: every cycle with alloc_req_i high pushes
// the expected grant/register into a queue; a negedge monitor pops and compares.
// Registered outputs are checked directly after each edge.
module tb_preg_free_list;
    import renaming_pkg::*;

    logic  clk_i = 1'b0;
    logic  rst_i;
    logic  alloc_req_i;
    logic  alloc_gnt_o;
    preg_t alloc_preg_o;
    logic  rel0_valid_i;
    preg_t rel0_preg_i;
    logic  rel1_valid_i;
    preg_t rel1_preg_i;
    preg_t free_count_o;
    logic  empty_o;
    logic  rel_error_o;

    typedef struct {
        bit    gnt;
        preg_t preg;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    preg_free_list dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .alloc_req_i  (alloc_req_i),
        .alloc_gnt_o  (alloc_gnt_o),
        .alloc_preg_o (alloc_preg_o),
        .rel0_valid_i (rel0_valid_i),
        .rel0_preg_i  (rel0_preg_i),
        .rel1_valid_i (rel1_valid_i),
        .rel1_preg_i  (rel1_preg_i),
        .free_count_o (free_count_o),
        .empty_o      (empty_o),
        .rel_error_o  (rel_error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: the allocator answers combinationally, so compare mid-cycle.
    always @(negedge clk_i) begin
        if (!rst_i && alloc_req_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_request: no expectation queued (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("alloc_gnt", int'(alloc_gnt_o), int'(e.gnt));
                if (e.gnt) check("alloc_preg", int'(alloc_preg_o), int'(e.preg));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic idle_inputs();
        alloc_req_i  = 1'b0;
        rel0_valid_i = 1'b0;
        rel0_preg_i  = '0;
        rel1_valid_i = 1'b0;
        rel1_preg_i  = '0;
    endtask

    // One clock cycle of stimulus; inputs return to idle just after the edge.
    task automatic step(input bit req, input bit v0, input int p0, input bit v1, input int p1,
                        input bit exp_gnt, input int exp_preg);
        alloc_req_i  = req;
        rel0_valid_i = v0;
        rel0_preg_i  = preg_t'(p0);
        rel1_valid_i = v1;
        rel1_preg_i  = preg_t'(p1);
        if (req) exp_q.push_back('{gnt: exp_gnt, preg: preg_t'(exp_preg)});
        @(posedge clk_i);
        #1;
        idle_inputs();
    endtask

    task automatic alloc_n(input int n, input int first);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 1, first + i);
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        #12 rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Reset state
        check("rst_gnt", int'(alloc_gnt_o), 0);
        check("rst_preg", int'(alloc_preg_o), 1);
        check("rst_count", int'(free_count_o), 63);
        check("rst_empty", int'(empty_o), 0);
        check("rst_err", int'(rel_error_o), 0);

        // 1: four grants in order pr1..pr4
        alloc_n(4, 1);
        check("s1_count", int'(free_count_o), 59);
        check("s1_err", int'(rel_error_o), 0);

        // 2: release pr3, reallocated first (LIFO), then pr5
        step(0, 1, 3, 0, 0, 0, 0);
        check("s2_count_rel", int'(free_count_o), 60);
        check("s2_err", int'(rel_error_o), 0);
        step(1, 0, 0, 0, 0, 1, 3);
        check("s2_count_re", int'(free_count_o), 59);
        step(1, 0, 0, 0, 0, 1, 5);
        check("s2_count_5", int'(free_count_o), 58);

        // 3: alloc + dual release in one cycle; rel1 ends on top
        do_reset();
        alloc_n(4, 1);
        step(1, 1, 2, 1, 4, 1, 5);
        check("s3_count", int'(free_count_o), 60);
        check("s3_err", int'(rel_error_o), 0);
        step(1, 0, 0, 0, 0, 1, 4);
        step(1, 0, 0, 0, 0, 1, 2);
        step(1, 0, 0, 0, 0, 1, 6);
        check("s3_count_end", int'(free_count_o), 57);

        // 4: illegal releases
        do_reset();
        alloc_n(7, 1);
        check("s4_count0", int'(free_count_o), 56);
        step(0, 1, 0, 0, 0, 0, 0);
        check("s4_pr0_err", int'(rel_error_o), 1);
        check("s4_pr0_count", int'(free_count_o), 56);
        step(0, 0, 0, 0, 0, 0, 0);
        check("s4_err_clear", int'(rel_error_o), 0);
        step(0, 0, 0, 1, 10, 0, 0);
        check("s4_free_err", int'(rel_error_o), 1);
        check("s4_free_count", int'(free_count_o), 56);
        step(0, 0, 0, 0, 0, 0, 0);
        check("s4_err_clear2", int'(rel_error_o), 0);
        step(0, 1, 7, 1, 7, 0, 0);
        check("s4_dup_err", int'(rel_error_o), 1);
        check("s4_dup_count", int'(free_count_o), 57);
        step(0, 0, 0, 0, 0, 0, 0);
        check("s4_err_clear3", int'(rel_error_o), 0);
        step(1, 0, 0, 0, 0, 1, 7);
        check("s4_count_end", int'(free_count_o), 56);

        // 5: drain the pool; a same-cycle release is not bypassed
        do_reset();
        alloc_n(63, 1);
        check("s5_count", int'(free_count_o), 0);
        check("s5_empty", int'(empty_o), 1);
        check("s5_preg_empty", int'(alloc_preg_o), 0);
        step(1, 1, 9, 0, 0, 0, 0);
        check("s5_count_rel", int'(free_count_o), 1);
        check("s5_empty_rel", int'(empty_o), 0);
        check("s5_err", int'(rel_error_o), 0);
        step(1, 0, 0, 0, 0, 1, 9);
        check("s5_count_end", int'(free_count_o), 0);

        // 6: asynchronous reset mid-cycle
        do_reset();
        alloc_n(10, 1);
        check("s6_count", int'(free_count_o), 53);
        #3 rst_i = 1'b1;
        #1;
        check("s6_async_count", int'(free_count_o), 63);
        check("s6_async_preg", int'(alloc_preg_o), 1);
        check("s6_async_empty", int'(empty_o), 0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        step(1, 0, 0, 0, 0, 1, 1);
        check("s6_count_end", int'(free_count_o), 62);

        @(posedge clk_i);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
